// File: rtl/hbuf_dpram_drain.sv
// Drains reader DPRAM port B into a 16-bit valid/ready stream, 4 words per 64-bit line, word 0 first.
// First word 2+P_RD_LAT cycles after dpram_run; a two-line buffer keeps the stream gap-free under full throughput.
module hbuf_dpram_drain #(
  parameter int P_ADR_WIDTH = 9,
  parameter int P_RD_LAT    = 1,
  parameter int P_LEN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dpram_run,
  input  logic [P_LEN_WIDTH-1:0] dpram_len,
  output logic                   dpram_busy,
  output logic [P_ADR_WIDTH-1:0] rd_addr,
  input  logic [63:0]            rd_dout,
  output logic [15:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [15:0]            xfer_cnt,
  output logic                   err
);

  localparam int MAX_WORDS = 4 << P_ADR_WIDTH;
  localparam int LCW       = P_LEN_WIDTH - 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [P_ADR_WIDTH-1:0] addr_q, addr_d;
  logic [LCW-1:0]         lines_q, lines_d;
  logic [P_LEN_WIDTH-1:0] words_q, words_d;
  logic [P_RD_LAT-1:0]    pipe_q, pipe_d;
  logic [63:0]            buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [1:0]             widx_q, widx_d;
  logic [15:0]            odat_q, odat_d;
  logic                   ovld_q, ovld_d;
  logic                   olast_q, olast_d;
  logic [15:0]            xcnt_q, xcnt_d;
  logic                   err_q, err_d;

  logic                   start, run_err, clamp;
  logic [P_LEN_WIDTH-1:0] cap_len;
  logic [LCW-1:0]         nlines;
  logic [2:0]             occ;
  logic [P_RD_LAT:0]      pipe_sh;
  logic                   issue, arriving, avail, hs, can_load, take, last_w, line_done, pop, push;
  logic [63:0]            head;

  assign start   = (state_q == S_IDLE) && !busy_q && dpram_run;
  assign run_err = dpram_run && !start;
  assign clamp   = int'(dpram_len) > MAX_WORDS;
  assign cap_len = clamp ? P_LEN_WIDTH'(MAX_WORDS) : dpram_len;
  assign nlines  = LCW'(cap_len[P_LEN_WIDTH-1:2]) + LCW'(|cap_len[1:0]);

  // Lines already requested but not yet returned count against buffer space.
  assign occ      = {1'b0, cnt_q} + 3'($countones(pipe_q));
  assign issue    = (state_q == S_RUN) && (lines_q != '0) && (occ < 3'd2);
  assign pipe_sh  = {pipe_q, issue};
  assign arriving = pipe_q[P_RD_LAT-1];

  // An empty buffer forwards the returning line straight to the output register.
  assign head      = (cnt_q != 2'd0) ? buf0_q : rd_dout;
  assign avail     = (cnt_q != 2'd0) || arriving;
  assign hs        = ovld_q && out_ready;
  assign can_load  = !ovld_q || out_ready;
  assign take      = (state_q == S_RUN) && avail && (words_q != '0) && can_load;
  assign last_w    = (words_q == P_LEN_WIDTH'(1));
  assign line_done = take && ((widx_q == 2'd3) || last_w);
  assign pop       = line_done && (cnt_q != 2'd0);
  assign push      = arriving && !((cnt_q == 2'd0) && line_done);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    lines_d = lines_q;
    words_d = words_q;
    pipe_d  = pipe_sh[P_RD_LAT-1:0];
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    odat_d  = odat_q;
    ovld_d  = ovld_q;
    olast_d = olast_q;
    xcnt_d  = xcnt_q;
    err_d   = err_q | run_err | (start & clamp);

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (cap_len == '0) begin
            xcnt_d = xcnt_q + 16'd1;
          end else begin
            state_d = S_RUN;
            addr_d  = '0;
            lines_d = nlines;
            words_d = cap_len;
            pipe_d  = '0;
            cnt_d   = 2'd0;
            widx_d  = 2'd0;
          end
        end
      end

      default: begin
        if (issue) begin
          lines_d = lines_q - LCW'(1);
          if (lines_q != LCW'(1)) addr_d = addr_q + P_ADR_WIDTH'(1);
        end

        case ({push, pop})
          2'b10: begin
            if (cnt_q == 2'd0) buf0_d = rd_dout;
            else               buf1_d = rd_dout;
            cnt_d = cnt_q + 2'd1;
          end
          2'b01: begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
          end
          2'b11: begin
            if (cnt_q == 2'd1) begin
              buf0_d = rd_dout;
            end else begin
              buf0_d = buf1_q;
              buf1_d = rd_dout;
            end
          end
          default: ;
        endcase

        if (take) begin
          widx_d  = line_done ? 2'd0 : widx_q + 2'd1;
          odat_d  = head[{widx_q, 4'b0000} +: 16];
          ovld_d  = 1'b1;
          olast_d = last_w;
          words_d = words_q - P_LEN_WIDTH'(1);
        end else if (hs) begin
          ovld_d  = 1'b0;
          olast_d = 1'b0;
        end

        if (hs && olast_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          xcnt_d  = xcnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      lines_q <= '0;
      words_q <= '0;
      pipe_q  <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= 2'd0;
      widx_q  <= 2'd0;
      odat_q  <= '0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      xcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      lines_q <= lines_d;
      words_q <= words_d;
      pipe_q  <= pipe_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      odat_q  <= odat_d;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
      xcnt_q  <= xcnt_d;
      err_q   <= err_d;
    end
  end

  assign dpram_busy = busy_q;
  assign rd_addr    = addr_q;
  assign out_data   = odat_q;
  assign out_valid  = ovld_q;
  assign out_last   = olast_q;
  assign xfer_cnt   = xcnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hbuf_dpram_drain.sv
// Scoreboard bench: expected words come from a word-indexed view of the DPRAM image, checked by a separate monitor.
module tb_hbuf_dpram_drain;
  localparam int AW   = 9;
  localparam int LAT  = 1;
  localparam int LENW = 16;
  localparam int MAXW = 4 << AW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            dpram_run = 1'b0;
  logic [LENW-1:0] dpram_len = '0;
  logic            dpram_busy;
  logic [AW-1:0]   rd_addr;
  logic [63:0]     rd_dout = '0;
  logic [15:0]     out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic [15:0]     xfer_cnt;
  logic            err;

  hbuf_dpram_drain #(.P_ADR_WIDTH(AW), .P_RD_LAT(LAT), .P_LEN_WIDTH(LENW)) dut (
    .clk(clk), .rst(rst), .dpram_run(dpram_run), .dpram_len(dpram_len),
    .dpram_busy(dpram_busy), .rd_addr(rd_addr), .rd_dout(rd_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .xfer_cnt(xfer_cnt), .err(err)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:511];
  always @(posedge clk) rd_dout <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  int          rdy_mode = 0;
  int          rdy_ph = 0;
  int          first_vld = -1;
  int          last_hs = -1;
  int          hs_total = 0;
  int          run_cyc = 0;
  int          done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dat = '0;
  logic        prev_last = 1'b0;
  logic [15:0] exp_xcnt = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_ph == 0) || (rdy_ph == 3);
          rdy_ph = (rdy_ph + 1) % 4;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall)
        check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_dat});
      check("valid_outside_run", out_valid && !dpram_busy, 0);
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        hs_total++;
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_word: got 0x%0h last=%0b, expected no word", out_data, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", {out_last, out_data}, mon_e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_xfer(input int len);
    int          cap;
    logic [63:0] w;
    cap = (len > MAXW) ? MAXW : len;
    for (int i = 0; i < cap; i++) begin
      w = mem[i / 4];
      exp_q.push_back({(i == cap - 1), w[(i % 4) * 16 +: 16]});
    end
    if (len > MAXW) exp_err = 1'b1;
    first_vld = -1;
    @(posedge clk);
    #1;
    dpram_run = 1'b1;
    dpram_len = LENW'(len);
    run_cyc   = cyc;
    @(posedge clk);
    #1;
    dpram_run = 1'b0;
  endtask

  task automatic finish_xfer(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 20000) begin
      @(negedge clk);
      if (!dpram_busy) done = 1'b1;
      else n++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
    done_cyc = cyc;
    exp_xcnt = exp_xcnt + 16'd1;
    check({name, "_xfer_cnt"}, xfer_cnt, exp_xcnt);
    check({name, "_err"}, err, exp_err);
    check({name, "_words_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {dpram_busy, out_valid, out_last, err, xfer_cnt, out_data, rd_addr}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    rdy_mode = 0;
    start_xfer(8);
    @(negedge clk);
    check("basic_busy_c1", dpram_busy, 1);
    check("basic_addr_c1", rd_addr, 0);
    finish_xfer("basic");
    check("basic_first_valid", first_vld - run_cyc, 3);
    check("basic_last_hs", last_hs - run_cyc, 10);
    check("basic_busy_drop", done_cyc - last_hs, 1);

    base = hs_total;
    start_xfer(6);
    finish_xfer("partial");
    check("partial_count", hs_total - base, 6);

    rdy_mode = 1;
    rdy_ph = 0;
    base = hs_total;
    start_xfer(12);
    finish_xfer("backpressure");
    check("backpressure_count", hs_total - base, 12);
    rdy_mode = 0;

    base = hs_total;
    start_xfer(0);
    @(negedge clk);
    check("zero_busy_hi", {dpram_busy, out_valid}, 2'b10);
    @(negedge clk);
    check("zero_busy_lo", {dpram_busy, out_valid}, 2'b00);
    exp_xcnt = exp_xcnt + 16'd1;
    check("zero_xfer_cnt", xfer_cnt, exp_xcnt);
    check("zero_words", hs_total - base, 0);

    rdy_mode = 2;
    start_xfer(12);
    repeat (3) @(posedge clk);
    #1;
    dpram_run = 1'b1;
    dpram_len = LENW'(3);
    exp_err = 1'b1;
    @(posedge clk);
    #1 dpram_run = 1'b0;
    finish_xfer("proto");

    rdy_mode = 0;
    base = hs_total;
    start_xfer(8);
    n = 0;
    while ((hs_total - base) < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reset_mid_reached_w5", (hs_total - base) >= 4, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_xcnt = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", {dpram_busy, out_valid, out_last, err, xfer_cnt, out_data, rd_addr}, 64'd0);
    base = hs_total;
    start_xfer(4);
    finish_xfer("after_reset");
    check("after_reset_count", hs_total - base, 4);

    base = hs_total;
    start_xfer(4000);
    finish_xfer("overrun");
    check("overrun_count", hs_total - base, MAXW);

    rdy_mode = 2;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 40; i++) mem[i] = {$urandom, $urandom};
      start_xfer(int'($urandom_range(1, 150)));
      finish_xfer("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
